// File: rtl/cc_bus_pkg.sv
// Shared types and address-window constants for the host bus master.
// The legality check lives here so every user decodes the map identically.
package cc_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_HALT,
    S_SETUP,
    S_STROBE,
    S_RELEASE
  } bus_state_e;

  localparam logic [3:0] NR_BASE   = 4'h8;
  localparam logic [3:0] IO_BASE   = 4'h9;
  localparam logic [1:0] NVRAM_SEL = 2'b00;

  // 8xxx is always reachable; in 9xxx only the NVRAM quarter unless I/O is opened up.
  function automatic logic addr_legal(input logic [15:0] addr, input logic allow_io);
    return (addr[15:12] == NR_BASE) ||
           ((addr[15:12] == IO_BASE) && (allow_io || (addr[11:10] == NVRAM_SEL)));
  endfunction

endpackage

// File: rtl/bus_halt_timer.sv
// Counts enabled cycles; done flags the TIMEOUT_CYC-th consecutive enabled cycle.
// Clear has priority and returns the count to zero.
module bus_halt_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count_q, count_d;

  assign done = enable && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !done) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/host_bus_master.sv
// Host-side bus master: halts the CPU, runs one PHI2-paced read or write cycle
// on its bus, and returns a single-cycle response. Bursts keep the CPU halted.
module host_bus_master
  import cc_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter bit          ALLOW_IO    = 1'b0
) (
  input  logic        CLK10,
  input  logic        RESET,
  input  logic        PHI2_EN,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WR,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_RDATA,
  output logic        RSP_ERR,
  output logic        CPU_HALTn,
  input  logic        CPU_HALTACK,
  output logic        BUS_OE,
  output logic [15:0] BA,
  output logic [7:0]  BD_OUT,
  input  logic [7:0]  BD_IN,
  output logic        WRITEn
);

  bus_state_e  state_q, state_d;
  logic [15:0] addr_q, addr_d, ba_q, ba_d;
  logic [7:0]  wdata_q, wdata_d, bd_q, bd_d, rdata_q, rdata_d;
  logic        wr_q, wr_d, burst_q, burst_d, armed_q, armed_d, ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic        latch_req, req_ready, timer_done;

  bus_halt_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_halt_timer (
    .clk    (CLK10),
    .rst    (RESET),
    .clear  (state_q != S_HALT),
    .enable (state_q == S_HALT),
    .done   (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    burst_d     = burst_q;
    ba_d        = ba_q;
    bd_d        = bd_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rdata_d     = 8'h00;
    req_ready   = ready_q;
    latch_req   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (REQ_VALID && ready_q) begin
          latch_req = 1'b1;
          burst_d   = 1'b0;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!addr_legal(addr_q, ALLOW_IO)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = S_IDLE;
        end else if (burst_q) begin
          state_d = S_SETUP;   // CPU is still parked from the previous cycle
        end else begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (CPU_HALTACK) begin
          state_d = S_SETUP;
        end else if (timer_done) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_SETUP: begin
        if (PHI2_EN && armed_q) begin
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        if (PHI2_EN && armed_q) begin
          rsp_valid_d = 1'b1;
          rdata_d     = wr_q ? 8'h00 : BD_IN;
          state_d     = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (REQ_VALID && CPU_HALTACK) begin
          req_ready = 1'b1;
          latch_req = 1'b1;
          burst_d   = 1'b1;
          state_d   = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (latch_req) begin
      addr_d  = REQ_ADDR;
      wr_d    = REQ_WR;
      wdata_d = REQ_WDATA;
    end

    // Bus-facing values are frozen on SETUP entry so they cannot move mid-cycle.
    if ((state_d == S_SETUP) && (state_q != S_SETUP)) begin
      ba_d = addr_q;
      bd_d = wr_q ? wdata_q : 8'h00;
    end

    // A phase only honours PHI2_EN once it has lasted at least one full cycle.
    armed_d = (state_d == state_q);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLK10 or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      addr_q      <= 16'h0000;
      wr_q        <= 1'b0;
      wdata_q     <= 8'h00;
      burst_q     <= 1'b0;
      armed_q     <= 1'b0;
      ready_q     <= 1'b0;
      ba_q        <= 16'h0000;
      bd_q        <= 8'h00;
      rdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      burst_q     <= burst_d;
      armed_q     <= armed_d;
      ready_q     <= ready_d;
      ba_q        <= ba_d;
      bd_q        <= bd_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign REQ_READY = req_ready;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_ERR   = rsp_err_q;
  assign RSP_RDATA = rdata_q;
  assign BA        = ba_q;
  assign BD_OUT    = bd_q;
  assign BUS_OE    = state_q inside {S_SETUP, S_STROBE, S_RELEASE};
  assign WRITEn    = !((state_q == S_STROBE) && wr_q);
  assign CPU_HALTn = !((state_q inside {S_HALT, S_SETUP, S_STROBE, S_RELEASE}) ||
                       ((state_q == S_CHECK) && burst_q));

endmodule

// File: tb/tb_host_bus_master.sv
// Self-checking bench: CPU, PHI2 and memory-device models around the master,
// with a memory/address-map reference model and randomized transactions.
module tb_host_bus_master;

  localparam int TIMEOUT = 255;
  localparam int PHI_PER = 4;

  logic        CLK10, RESET, PHI2_EN, REQ_VALID, REQ_READY, REQ_WR;
  logic [15:0] REQ_ADDR, BA;
  logic [7:0]  REQ_WDATA, RSP_RDATA, BD_OUT, BD_IN;
  logic        RSP_VALID, RSP_ERR, CPU_HALTn, CPU_HALTACK, BUS_OE, WRITEn;

  int checks = 0;
  int failures = 0;

  logic [7:0] dev_mem [0:65535];
  logic [7:0] ref_mem [0:65535];

  int ack_delay = 0;
  bit ack_en = 1;
  int low_cnt = 0;
  int phi_cnt = 0;

  int mon_halt_low, mon_oe, mon_oe_noack, mon_phi_oe, mon_phi_first;
  int mon_ba_chg, mon_wr_low, mon_wr_nooe, mon_wr_badba;
  logic [15:0] mon_exp_ba, ba_prev;
  logic oe_prev = 1'b0;

  host_bus_master #(.TIMEOUT_CYC(TIMEOUT), .ALLOW_IO(1'b0)) dut (
    .CLK10(CLK10), .RESET(RESET), .PHI2_EN(PHI2_EN),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .CPU_HALTn(CPU_HALTn), .CPU_HALTACK(CPU_HALTACK),
    .BUS_OE(BUS_OE), .BA(BA), .BD_OUT(BD_OUT), .BD_IN(BD_IN), .WRITEn(WRITEn)
  );

  initial begin
    CLK10 = 1'b0;
    forever #5 CLK10 = ~CLK10;
  end

  // PHI2 strobe, CPU halt handshake and device read data change just after the edge.
  initial begin
    PHI2_EN = 1'b0;
    CPU_HALTACK = 1'b0;
    BD_IN = 8'h00;
    forever begin
      @(posedge CLK10);
      #2;
      phi_cnt = (phi_cnt + 1) % PHI_PER;
      PHI2_EN = (phi_cnt == 0);
      if (!CPU_HALTn) begin
        if (ack_en && low_cnt >= ack_delay) CPU_HALTACK = 1'b1;
        low_cnt++;
      end else begin
        low_cnt = 0;
        CPU_HALTACK = 1'b0;
      end
      BD_IN = dev_mem[BA];
    end
  end

  // Bus monitor and memory device write port.
  initial begin
    forever begin
      @(negedge CLK10);
      #1;
      if (!CPU_HALTn) mon_halt_low++;
      if (BUS_OE) mon_oe++;
      if (BUS_OE && !CPU_HALTACK) mon_oe_noack++;
      if (BUS_OE && PHI2_EN) mon_phi_oe++;
      if (BUS_OE && !oe_prev && PHI2_EN) mon_phi_first++;
      if (BUS_OE && oe_prev && (BA != ba_prev)) mon_ba_chg++;
      if (!WRITEn) begin
        mon_wr_low++;
        if (!BUS_OE) mon_wr_nooe++;
        if (BA != mon_exp_ba) mon_wr_badba++;
        if (BUS_OE) dev_mem[BA] = BD_OUT;
      end
      oe_prev = BUS_OE;
      ba_prev = BA;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic mon_clear();
    mon_halt_low = 0; mon_oe = 0; mon_oe_noack = 0; mon_phi_oe = 0; mon_phi_first = 0;
    mon_ba_chg = 0; mon_wr_low = 0; mon_wr_nooe = 0; mon_wr_badba = 0;
  endtask

  // Issues one request from a negedge and returns what the response looked like.
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                         output int lat, output logic err, output logic [7:0] rdata,
                         output logic phi_before, output logic halt_at_rsp, output logic to);
    int n;
    mon_clear();
    mon_exp_ba = addr;
    REQ_WR = wr; REQ_ADDR = addr; REQ_WDATA = wdata; REQ_VALID = 1'b1;
    n = 0;
    to = 1'b0;
    while (!REQ_READY && n < 100) begin @(negedge CLK10); n++; end
    if (n >= 100) to = 1'b1;
    @(negedge CLK10);
    REQ_VALID = 1'b0;
    lat = 1;
    phi_before = 1'b0;
    while (!RSP_VALID && lat < 2000) begin
      phi_before = PHI2_EN;
      @(negedge CLK10);
      lat++;
    end
    if (lat >= 2000) to = 1'b1;
    err = RSP_ERR; rdata = RSP_RDATA; halt_at_rsp = CPU_HALTn;
    @(negedge CLK10);
  endtask

  task automatic test_reset();
    RESET = 1'b1; REQ_VALID = 1'b0; REQ_WR = 1'b0; REQ_ADDR = 16'h0; REQ_WDATA = 8'h0;
    repeat (3) @(negedge CLK10);
    checks++;
    if ({REQ_READY, RSP_VALID, RSP_ERR, RSP_RDATA} !== 11'b0) begin
      failures++;
      $display("FAIL reset_rsp: ready/valid/err/rdata=%b, required all zero",
               {REQ_READY, RSP_VALID, RSP_ERR, RSP_RDATA});
    end
    checks++;
    if ({CPU_HALTn, BUS_OE, WRITEn} !== 3'b101) begin
      failures++;
      $display("FAIL reset_ctl: haltn/oe/writen=%b, required 101", {CPU_HALTn, BUS_OE, WRITEn});
    end
    checks++;
    if ({BA, BD_OUT} !== 24'h0) begin
      failures++;
      $display("FAIL reset_bus: BA=%h BD_OUT=%h, required 0000/00", BA, BD_OUT);
    end
    RESET = 1'b0;
    #1;
    checks++;
    if (REQ_READY !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_early: REQ_READY=%b, required 0 before the first edge", REQ_READY);
    end
    @(negedge CLK10);
    checks++;
    if (REQ_READY !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_rise: REQ_READY=%b, required 1", REQ_READY);
    end
    $display("txn reset: ready=%b haltn=%b oe=%b", REQ_READY, CPU_HALTn, BUS_OE);
  endtask

  task automatic test_write_9010();
    int lat; logic err, phi_b, h_rsp, to; logic [7:0] rd;
    ack_delay = 3;
    run_txn(1'b1, 16'h9010, 8'h5A, lat, err, rd, phi_b, h_rsp, to);
    $display("txn write 9010<=5A: lat=%0d err=%b wr_low=%0d", lat, err, mon_wr_low);
    checks++;
    if (to !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL w9010_rsp: timeout=%b err=%b, required 0/0", to, err);
    end
    checks++;
    if (mon_wr_low != PHI_PER || mon_wr_badba != 0) begin
      failures++;
      $display("FAIL w9010_strobe: writen_low_cycles=%0d bad_ba=%0d, required %0d/0",
               mon_wr_low, mon_wr_badba, PHI_PER);
    end
    checks++;
    if (h_rsp !== 1'b0 || CPU_HALTn !== 1'b1) begin
      failures++;
      $display("FAIL w9010_haltn: at_rsp=%b after=%b, required 0/1", h_rsp, CPU_HALTn);
    end
    checks++;
    if (dev_mem[16'h9010] !== 8'h5A) begin
      failures++; $display("FAIL w9010_mem: device=%h, required 5a", dev_mem[16'h9010]);
    end
    ref_mem[16'h9010] = 8'h5A;
  endtask

  task automatic test_read_8123();
    int lat; logic err, phi_b, h_rsp, to; logic [7:0] rd;
    dev_mem[16'h8123] = 8'hC3; ref_mem[16'h8123] = 8'hC3;
    ack_delay = 1;
    run_txn(1'b0, 16'h8123, 8'h00, lat, err, rd, phi_b, h_rsp, to);
    $display("txn read 8123: lat=%0d err=%b rdata=%h", lat, err, rd);
    checks++;
    if (rd !== 8'hC3 || err !== 1'b0 || to !== 1'b0) begin
      failures++;
      $display("FAIL r8123_data: rdata=%h err=%b timeout=%b, required c3/0/0", rd, err, to);
    end
    checks++;
    if (mon_oe_noack != 0 || mon_oe == 0) begin
      failures++;
      $display("FAIL r8123_oe: oe_without_ack=%0d oe_cycles=%0d, required 0/nonzero", mon_oe_noack, mon_oe);
    end
    checks++;
    if (phi_b !== 1'b1) begin
      failures++; $display("FAIL r8123_latency: phi2 before rsp=%b, required 1", phi_b);
    end
  endtask

  task automatic test_illegal_wdog();
    int lat; logic err, phi_b, h_rsp, to; logic [7:0] rd;
    run_txn(1'b1, 16'h9E00, 8'h77, lat, err, rd, phi_b, h_rsp, to);
    $display("txn write 9E00: lat=%0d err=%b rdata=%h", lat, err, rd);
    checks++;
    if (lat != 2 || err !== 1'b1 || rd !== 8'h00) begin
      failures++;
      $display("FAIL wdog_rsp: lat=%0d err=%b rdata=%h, required 2/1/00", lat, err, rd);
    end
    checks++;
    if (mon_halt_low != 0 || mon_wr_low != 0 || mon_oe != 0) begin
      failures++;
      $display("FAIL wdog_bus: halt_low=%0d writen_low=%0d oe=%0d, required 0/0/0",
               mon_halt_low, mon_wr_low, mon_oe);
    end
  endtask

  task automatic test_timeout();
    int lat; logic err, phi_b, h_rsp, to; logic [7:0] rd;
    ack_en = 0;
    run_txn(1'b0, 16'h8000, 8'h00, lat, err, rd, phi_b, h_rsp, to);
    ack_en = 1;
    $display("txn read 8000 no-ack: lat=%0d err=%b halt_low=%0d", lat, err, mon_halt_low);
    checks++;
    if (lat != 2 + TIMEOUT || err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_rsp: lat=%0d err=%b, required %0d/1", lat, err, 2 + TIMEOUT);
    end
    checks++;
    if (mon_halt_low != TIMEOUT || h_rsp !== 1'b1 || mon_oe != 0) begin
      failures++;
      $display("FAIL timeout_halt: halt_low=%0d haltn_at_rsp=%b oe=%0d, required %0d/1/0",
               mon_halt_low, h_rsp, mon_oe, TIMEOUT);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a1, a2; logic [7:0] d1, d2;
    int n, pulses, gap; logic seen_low, rel_ready;
    a1 = {4'h8, 12'($urandom)};
    a2 = a1 ^ 16'h0101;
    d1 = 8'($urandom); d2 = ~d1;
    ack_delay = 2;
    mon_clear();
    mon_exp_ba = a1;
    REQ_WR = 1'b1; REQ_ADDR = a1; REQ_WDATA = d1; REQ_VALID = 1'b1;
    n = 0;
    while (!REQ_READY && n < 100) begin @(negedge CLK10); n++; end
    @(negedge CLK10);
    REQ_ADDR = a2; REQ_WDATA = d2;
    pulses = 0; gap = 0; seen_low = 1'b0; rel_ready = 1'b0; n = 0;
    while (pulses < 2 && n < 3000) begin
      if (!CPU_HALTn) seen_low = 1'b1;
      else if (seen_low) gap++;
      if (RSP_VALID) begin
        pulses++;
        if (pulses == 1) rel_ready = REQ_READY;
      end
      @(negedge CLK10);
      n++;
      if (pulses == 1) begin REQ_VALID = 1'b0; mon_exp_ba = a2; end
    end
    REQ_VALID = 1'b0;
    $display("txn burst %h<=%h %h<=%h: pulses=%0d gap=%0d ready_in_release=%b",
             a1, d1, a2, d2, pulses, gap, rel_ready);
    checks++;
    if (pulses != 2 || rel_ready !== 1'b1) begin
      failures++;
      $display("FAIL burst_rsp: pulses=%0d ready_in_release=%b, required 2/1", pulses, rel_ready);
    end
    checks++;
    if (gap != 0) begin
      failures++; $display("FAIL burst_haltn: haltn high cycles=%0d, required 0", gap);
    end
    checks++;
    if (dev_mem[a1] !== d1 || dev_mem[a2] !== d2) begin
      failures++;
      $display("FAIL burst_mem: device=%h/%h, required %h/%h", dev_mem[a1], dev_mem[a2], d1, d2);
    end
    checks++;
    if (CPU_HALTn !== 1'b1 || mon_wr_badba != 0) begin
      failures++;
      $display("FAIL burst_end: haltn=%b bad_ba=%0d, required 1/0", CPU_HALTn, mon_wr_badba);
    end
    ref_mem[a1] = d1; ref_mem[a2] = d2;
  endtask

  task automatic test_reset_strobe();
    int n, rsp_seen;
    dev_mem[16'h8456] = 8'h3C; ref_mem[16'h8456] = 8'h3C;
    ack_delay = 1;
    mon_clear();
    mon_exp_ba = 16'h8456;
    REQ_WR = 1'b1; REQ_ADDR = 16'h8456; REQ_WDATA = 8'h3C; REQ_VALID = 1'b1;
    n = 0;
    while (!REQ_READY && n < 100) begin @(negedge CLK10); n++; end
    @(negedge CLK10);
    REQ_VALID = 1'b0;
    n = 0;
    while (WRITEn !== 1'b0 && n < 200) begin @(negedge CLK10); n++; end
    checks++;
    if (n >= 200) begin
      failures++; $display("FAIL rst_strobe_reach: WRITEn never went low within 200 cycles");
    end
    RESET = 1'b1;
    #1;
    $display("txn reset in strobe: writen=%b oe=%b haltn=%b valid=%b", WRITEn, BUS_OE, CPU_HALTn, RSP_VALID);
    checks++;
    if ({WRITEn, BUS_OE, CPU_HALTn, RSP_VALID} !== 4'b1010) begin
      failures++;
      $display("FAIL rst_strobe_bus: writen/oe/haltn/valid=%b, required 1010",
               {WRITEn, BUS_OE, CPU_HALTn, RSP_VALID});
    end
    rsp_seen = 0;
    repeat (2) begin @(negedge CLK10); if (RSP_VALID) rsp_seen++; end
    RESET = 1'b0;
    repeat (4) begin @(negedge CLK10); if (RSP_VALID || BUS_OE) rsp_seen++; end
    checks++;
    if (rsp_seen != 0) begin
      failures++; $display("FAIL rst_strobe_quiet: valid/oe cycles after reset=%0d, required 0", rsp_seen);
    end
  endtask

  task automatic test_random();
    int lat, reg_sel, nib; logic err, phi_b, h_rsp, to, wr, legal; logic [7:0] rd, wd;
    logic [15:0] addr; logic [3:0] top;
    for (int t = 0; t < 40; t++) begin
      reg_sel = $urandom_range(0, 3);
      case (reg_sel)
        0: addr = {4'h8, 12'($urandom)};
        1: addr = {4'h9, 2'b00, 10'($urandom)};
        2: addr = {4'h9, 2'($urandom_range(1, 3)), 10'($urandom)};
        default: begin
          nib = $urandom_range(0, 13);
          top = (nib >= 8) ? 4'(nib + 2) : 4'(nib);
          addr = {top, 12'($urandom)};
        end
      endcase
      wr = 1'($urandom);
      wd = 8'($urandom);
      ack_delay = $urandom_range(0, 6);
      legal = (addr >= 16'h8000) && (addr <= 16'h93FF);
      run_txn(wr, addr, wd, lat, err, rd, phi_b, h_rsp, to);
      $display("txn rnd%0d %s %h wd=%h ack=%0d: lat=%0d err=%b rd=%h", t, wr ? "wr" : "rd",
               addr, wd, ack_delay, lat, err, rd);
      checks++;
      if (to !== 1'b0 || err !== !legal) begin
        failures++;
        $display("FAIL rnd_err: addr=%h err=%b timeout=%b, required err=%b", addr, err, to, !legal);
      end
      if (!legal) begin
        checks++;
        if (lat != 2 || mon_halt_low != 0 || mon_oe != 0) begin
          failures++;
          $display("FAIL rnd_reject: addr=%h lat=%0d halt_low=%0d oe=%0d, required 2/0/0",
                   addr, lat, mon_halt_low, mon_oe);
        end
      end else begin
        checks++;
        if (mon_wr_low != (wr ? PHI_PER : 0) || mon_wr_nooe != 0 || mon_wr_badba != 0) begin
          failures++;
          $display("FAIL rnd_strobe: addr=%h writen_low=%0d no_oe=%0d bad_ba=%0d, required %0d/0/0",
                   addr, mon_wr_low, mon_wr_nooe, mon_wr_badba, wr ? PHI_PER : 0);
        end
        checks++;
        if (phi_b !== 1'b1 || (mon_phi_oe - mon_phi_first) != 2 || mon_ba_chg != 0) begin
          failures++;
          $display("FAIL rnd_phase: addr=%h phi_before=%b counted_strobes=%0d ba_changes=%0d, required 1/2/0",
                   addr, phi_b, mon_phi_oe - mon_phi_first, mon_ba_chg);
        end
        checks++;
        if (mon_oe_noack != 0 || CPU_HALTn !== 1'b1) begin
          failures++;
          $display("FAIL rnd_release: addr=%h oe_without_ack=%0d haltn_after=%b, required 0/1",
                   addr, mon_oe_noack, CPU_HALTn);
        end
        if (wr) begin
          ref_mem[addr] = wd;
          checks++;
          if (dev_mem[addr] !== wd) begin
            failures++;
            $display("FAIL rnd_write: addr=%h device=%h, required %h", addr, dev_mem[addr], wd);
          end
        end else begin
          checks++;
          if (rd !== ref_mem[addr]) begin
            failures++;
            $display("FAIL rnd_read: addr=%h rdata=%h, required %h", addr, rd, ref_mem[addr]);
          end
        end
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    REQ_VALID = 1'b0; REQ_WR = 1'b0; REQ_ADDR = 16'h0; REQ_WDATA = 8'h0;
    mon_exp_ba = 16'h0;
    for (int i = 0; i < 65536; i++) begin
      dev_mem[i] = 8'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    mon_clear();
    test_reset();
    test_write_9010();
    test_read_8123();
    test_illegal_wdog();
    test_timeout();
    test_back_to_back();
    test_reset_strobe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
